// File: rtl/jelly3_axi4_read_splitter_if.sv
// AXI4 read-address and read-data channel bundle used on both sides of the read splitter.
interface jelly3_axi4_read_splitter_if #(
  parameter int ID_BITS   = 8,
  parameter int ADDR_BITS = 12,
  parameter int DATA_BITS = 32
);
  logic [ID_BITS-1:0]   arid;
  logic [ADDR_BITS-1:0] araddr;
  logic [7:0]           arlen;
  logic [2:0]           arsize;
  logic [1:0]           arburst;
  logic                 arvalid;
  logic                 arready;
  logic [ID_BITS-1:0]   rid;
  logic [DATA_BITS-1:0] rdata;
  logic [1:0]           rresp;
  logic                 rlast;
  logic                 rvalid;
  logic                 rready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arvalid, rready,
    input  arready, rid, rdata, rresp, rlast, rvalid
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
    output arready, rid, rdata, rresp, rlast, rvalid
  );
endinterface

// File: rtl/jelly3_axi4_read_splitter.sv
// Splits long INCR read bursts into sub-bursts of at most MAX_LEN beats and
// re-merges the R stream so the upstream master sees one burst with one rlast.
module jelly3_axi4_read_splitter #(
  parameter int ID_BITS       = 8,
  parameter int ADDR_BITS     = 12,
  parameter int DATA_BITS     = 32,
  parameter int MAX_LEN       = 16,
  parameter int FIFO_PTR_BITS = 3
) (
  input  logic                          aresetn,
  input  logic                          aclk,
  input  logic                          aclken,
  jelly3_axi4_read_splitter_if.slave    s_axi,
  jelly3_axi4_read_splitter_if.master   m_axi
);
  // state    | meaning
  // ST_IDLE  | waiting for an upstream AR (s_arready high)
  // ST_ISSUE | emitting sub-bursts downstream until the final one is accepted
  typedef enum logic {ST_IDLE, ST_ISSUE} state_t;

  localparam int         FIFO_DEPTH = 1 << FIFO_PTR_BITS;
  localparam logic [8:0] MAX_LEN9   = 9'(MAX_LEN);

  state_t                 r_state;
  logic                   r_s_arready;
  logic [ID_BITS-1:0]     r_id;
  logic [2:0]             r_size;
  logic [1:0]             r_burst;
  logic [ADDR_BITS-1:0]   r_addr;
  logic [8:0]             r_remain;
  logic [7:0]             r_len_orig;
  logic                   r_nosplit;
  logic [FIFO_DEPTH-1:0]  r_fifo;
  logic [FIFO_PTR_BITS:0] r_wptr;
  logic [FIFO_PTR_BITS:0] r_rptr;

  logic                   w_fifo_full;
  logic                   w_fifo_empty;
  logic                   w_fifo_head;
  logic                   w_last_sub;
  logic                   w_m_arvalid;
  logic                   w_pop;
  logic [7:0]             w_m_arlen;
  logic [ADDR_BITS-1:0]   w_step;
  logic [DATA_BITS-1:0]   w_rdata;

  assign w_fifo_empty = (r_wptr == r_rptr);
  assign w_fifo_full  = (r_wptr[FIFO_PTR_BITS] != r_rptr[FIFO_PTR_BITS]) &&
                        (r_wptr[FIFO_PTR_BITS-1:0] == r_rptr[FIFO_PTR_BITS-1:0]);
  assign w_fifo_head  = r_fifo[r_rptr[FIFO_PTR_BITS-1:0]];

  // FIXED/WRAP bursts go out as a single unchanged request
  assign w_last_sub  = r_nosplit || (r_remain <= MAX_LEN9);
  assign w_m_arlen   = r_nosplit  ? r_len_orig :
                       w_last_sub ? 8'(r_remain - 9'd1) : 8'(MAX_LEN - 1);
  assign w_step      = ADDR_BITS'(MAX_LEN) << r_size;
  assign w_m_arvalid = (r_state == ST_ISSUE) && !w_fifo_full;
  // Handshakes are qualified by aclken, the bus shares the enable
  assign w_pop       = m_axi.rvalid && s_axi.rready && m_axi.rlast && !w_fifo_empty;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state     <= ST_IDLE;
      r_s_arready <= 1'b0;
      r_id        <= '0;
      r_size      <= '0;
      r_burst     <= '0;
      r_addr      <= '0;
      r_remain    <= '0;
      r_len_orig  <= '0;
      r_nosplit   <= 1'b0;
      r_fifo      <= '0;
      r_wptr      <= '0;
      r_rptr      <= '0;
    end else if (aclken) begin
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      case (r_state)
        ST_IDLE: begin
          if (r_s_arready && s_axi.arvalid) begin
            r_id        <= s_axi.arid;
            r_size      <= s_axi.arsize;
            r_burst     <= s_axi.arburst;
            r_addr      <= s_axi.araddr;
            r_remain    <= 9'(s_axi.arlen) + 9'd1;
            r_len_orig  <= s_axi.arlen;
            r_nosplit   <= (s_axi.arburst != 2'b01);
            r_s_arready <= 1'b0;
            r_state     <= ST_ISSUE;
          end else begin
            r_s_arready <= 1'b1;
          end
        end
        ST_ISSUE: begin
          if (w_m_arvalid && m_axi.arready) begin
            r_fifo[r_wptr[FIFO_PTR_BITS-1:0]] <= w_last_sub;
            r_wptr   <= r_wptr + 1'b1;
            r_remain <= r_remain - MAX_LEN9;
            r_addr   <= r_addr + w_step;
            if (w_last_sub) begin
              r_state     <= ST_IDLE;
              r_s_arready <= 1'b1;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign s_axi.arready = r_s_arready;
  assign m_axi.arvalid = w_m_arvalid;
  assign m_axi.arid    = r_id;
  assign m_axi.araddr  = r_addr;
  assign m_axi.arlen   = w_m_arlen;
  assign m_axi.arsize  = r_size;
  assign m_axi.arburst = r_burst;

  // An empty FIFO with rvalid high is a protocol error; rlast then passes unmasked
  assign w_rdata       = m_axi.rdata;
  assign s_axi.rdata   = w_rdata;
  assign s_axi.rid     = m_axi.rid;
  assign s_axi.rresp   = m_axi.rresp;
  assign s_axi.rvalid  = m_axi.rvalid;
  assign s_axi.rlast   = m_axi.rlast && (w_fifo_empty || w_fifo_head);
  assign m_axi.rready  = s_axi.rready;
endmodule

// File: tb/tb_jelly3_axi4_read_splitter.sv
// Bench for the read splitter: directed test-plan scenarios plus random bursts
// against a burst-level reference model and an in-order downstream memory model.
module tb_jelly3_axi4_read_splitter;
  localparam int ID_BITS = 8, ADDR_BITS = 12, DATA_BITS = 32, MAX_LEN = 16, FIFO_PTR_BITS = 1;

  typedef struct packed {
    logic [7:0]  id;
    logic [11:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
  } ar_t;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
    logic [7:0]  id;
    logic [1:0]  resp;
  } beat_t;

  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  logic aclken = 1'b1;
  always #5 aclk = ~aclk;

  jelly3_axi4_read_splitter_if #(.ID_BITS(ID_BITS), .ADDR_BITS(ADDR_BITS), .DATA_BITS(DATA_BITS)) s_if ();
  jelly3_axi4_read_splitter_if #(.ID_BITS(ID_BITS), .ADDR_BITS(ADDR_BITS), .DATA_BITS(DATA_BITS)) m_if ();

  jelly3_axi4_read_splitter #(
    .ID_BITS(ID_BITS), .ADDR_BITS(ADDR_BITS), .DATA_BITS(DATA_BITS),
    .MAX_LEN(MAX_LEN), .FIFO_PTR_BITS(FIFO_PTR_BITS)
  ) dut (
    .aresetn(aresetn), .aclk(aclk), .aclken(aclken), .s_axi(s_if), .m_axi(m_if)
  );

  int checks = 0;
  int failures = 0;
  logic [31:0] mem [0:1023];
  ar_t   ds_q[$];
  ar_t   mon_ar[$];
  ar_t   exp_ar[$];
  beat_t up_q[$];
  int    ds_beat = 0;
  bit    r_stall = 0;
  bit    rand_ready = 0;
  bit    prev_ar_wait = 0;
  ar_t   prev_ar;

  function automatic logic [11:0] beat_addr(input ar_t a, input int i);
    int bytes, total, base, off;
    bytes = 1 << a.size;
    case (a.burst)
      2'b00: return a.addr;
      2'b10: begin
        total = (int'(a.len) + 1) * bytes;
        base  = (int'(a.addr) / total) * total;
        off   = (int'(a.addr) - base + i * bytes) % total;
        return 12'(base + off);
      end
      default: return 12'(int'(a.addr) + i * bytes);
    endcase
  endfunction

  function automatic logic [31:0] mem_at(input logic [11:0] a);
    return mem[int'(a[11:2])];
  endfunction

  // Reference split: consecutive MAX_LEN-beat chunks of an INCR burst
  function automatic void model_split(input ar_t r);
    int  rem, k;
    ar_t s;
    exp_ar.delete();
    if (r.burst != 2'b01) begin
      exp_ar.push_back(r);
      return;
    end
    rem = int'(r.len) + 1;
    k = 0;
    while (rem > 0) begin
      s = r;
      s.addr = 12'(int'(r.addr) + k * MAX_LEN * (1 << r.size));
      s.len  = 8'(((rem > MAX_LEN) ? MAX_LEN : rem) - 1);
      exp_ar.push_back(s);
      rem -= MAX_LEN;
      k++;
    end
  endfunction

  task automatic step();
    bit  hs_sar, hs_mar, hs_r;
    ar_t cur;
    @(negedge aclk);
    hs_sar = aclken && aresetn && s_if.arvalid && s_if.arready;
    hs_mar = aclken && aresetn && m_if.arvalid && m_if.arready;
    hs_r   = aclken && s_if.rvalid && s_if.rready;
    cur = {m_if.arid, m_if.araddr, m_if.arlen, m_if.arsize, m_if.arburst};
    if (prev_ar_wait && m_if.arvalid) begin
      checks++;
      if (cur !== prev_ar) begin
        failures++;
        $display("FAIL ar_stable got=%h want=%h", cur, prev_ar);
      end
    end
    prev_ar_wait = m_if.arvalid && !hs_mar;
    prev_ar = cur;
    if (hs_mar) begin
      ds_q.push_back(cur);
      mon_ar.push_back(cur);
    end
    if (hs_r) up_q.push_back({s_if.rdata, s_if.rlast, s_if.rid, s_if.rresp});
    @(posedge aclk);
    #1;
    if (hs_sar) s_if.arvalid = 1'b0;
    if (hs_r && ds_q.size() > 0) begin
      ds_beat++;
      if (ds_beat > int'(ds_q[0].len)) begin
        void'(ds_q.pop_front());
        ds_beat = 0;
      end
    end
    if (!(m_if.rvalid && !hs_r)) begin
      if (ds_q.size() > 0 && !r_stall && (!rand_ready || $urandom_range(0, 3) != 0)) begin
        m_if.rvalid = 1'b1;
        m_if.rid    = ds_q[0].id;
        m_if.rdata  = mem_at(beat_addr(ds_q[0], ds_beat));
        m_if.rresp  = ds_q[0].id[1:0];
        m_if.rlast  = (ds_beat == int'(ds_q[0].len));
      end else begin
        m_if.rvalid = 1'b0;
        m_if.rlast  = 1'b0;
      end
    end
    m_if.arready = rand_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
    s_if.rready  = rand_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
  endtask

  task automatic start_read(input ar_t r);
    mon_ar.delete();
    up_q.delete();
    s_if.arid    = r.id;
    s_if.araddr  = r.addr;
    s_if.arlen   = r.len;
    s_if.arsize  = r.size;
    s_if.arburst = r.burst;
    s_if.arvalid = 1'b1;
  endtask

  task automatic wait_done(input int nbeats, input string name);
    int n;
    n = 0;
    while ((up_q.size() < nbeats || ds_q.size() != 0 || s_if.arvalid || m_if.arvalid) && n < 4000) begin
      step();
      n++;
    end
    checks++;
    if (n >= 4000) begin
      failures++;
      $display("FAIL %s_timeout beats=%0d need=%0d", name, up_q.size(), nbeats);
    end
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if (s_if.arready !== 1'b0 || m_if.arvalid !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs arready=%b arvalid=%b want 0/0", s_if.arready, m_if.arvalid);
    end
    @(posedge aclk);
    #1;
    aresetn = 1'b1;
    step();
    checks++;
    if (s_if.arready !== 1'b1) begin
      failures++;
      $display("FAIL reset_release_arready got=%b want=1", s_if.arready);
    end
  endtask

  task automatic test_split_64();
    int nlast;
    start_read('{id: 8'h11, addr: 12'h000, len: 8'd63, size: 3'd2, burst: 2'b01});
    wait_done(64, "split64");
    checks++;
    if (mon_ar.size() != 4) begin
      failures++;
      $display("FAIL split64_ar_count got=%0d want=4", mon_ar.size());
    end
    for (int k = 0; k < mon_ar.size() && k < 4; k++) begin
      checks++;
      if (mon_ar[k].addr !== 12'(k * 64) || mon_ar[k].len !== 8'd15) begin
        failures++;
        $display("FAIL split64_ar%0d addr=%h len=%0d want addr=%h len=15", k, mon_ar[k].addr, mon_ar[k].len, k * 64);
      end
    end
    nlast = 0;
    for (int i = 0; i < up_q.size(); i++) begin
      if (up_q[i].last) nlast++;
      checks++;
      if (up_q[i].data !== mem_at(12'(i * 4)) || up_q[i].last !== (i == 63)) begin
        failures++;
        $display("FAIL split64_beat%0d data=%h last=%b want data=%h last=%b", i, up_q[i].data, up_q[i].last, mem_at(12'(i * 4)), (i == 63));
      end
    end
    checks++;
    if (up_q.size() != 64 || nlast != 1) begin
      failures++;
      $display("FAIL split64_beats got=%0d lasts=%0d want 64/1", up_q.size(), nlast);
    end
  endtask

  task automatic test_single();
    start_read('{id: 8'h22, addr: 12'h020, len: 8'd0, size: 3'd2, burst: 2'b01});
    wait_done(1, "single");
    checks++;
    if (mon_ar.size() != 1 || mon_ar[0].addr !== 12'h020 || mon_ar[0].len !== 8'd0) begin
      failures++;
      $display("FAIL single_ar count=%0d first=%h want one addr=020 len=0", mon_ar.size(), (mon_ar.size() > 0) ? mon_ar[0] : '0);
    end
    checks++;
    if (up_q.size() != 1 || up_q[0].data !== 32'h12345678 || up_q[0].last !== 1'b1 || up_q[0].id !== 8'h22) begin
      failures++;
      $display("FAIL single_beat count=%0d beat=%h want data=12345678 last=1 id=22", up_q.size(), (up_q.size() > 0) ? up_q[0] : '0);
    end
  endtask

  task automatic test_len20();
    start_read('{id: 8'h33, addr: 12'h100, len: 8'd20, size: 3'd2, burst: 2'b01});
    wait_done(21, "len20");
    checks++;
    if (mon_ar.size() != 2 || mon_ar[0].len !== 8'd15 || mon_ar[0].addr !== 12'h100 ||
        mon_ar[1].len !== 8'd4 || mon_ar[1].addr !== 12'h140) begin
      failures++;
      $display("FAIL len20_ars count=%0d want 100/15 then 140/4", mon_ar.size());
    end
    checks++;
    if (up_q.size() != 21 || up_q[15].last !== 1'b0 || up_q[20].last !== 1'b1) begin
      failures++;
      $display("FAIL len20_rlast count=%0d want 21 beats, mid rlast masked, final rlast set", up_q.size());
    end
  endtask

  task automatic test_wrap_fixed();
    ar_t r;
    r = '{id: 8'h05, addr: 12'h004, len: 8'd3, size: 3'd2, burst: 2'b10};
    start_read(r);
    wait_done(4, "wrap");
    checks++;
    if (mon_ar.size() != 1 || mon_ar[0] !== r) begin
      failures++;
      $display("FAIL wrap_ar count=%0d got=%h want=%h", mon_ar.size(), (mon_ar.size() > 0) ? mon_ar[0] : '0, r);
    end
    for (int i = 0; i < up_q.size(); i++) begin
      checks++;
      if (up_q[i].data !== mem[(i + 1) % 4] || up_q[i].last !== (i == 3)) begin
        failures++;
        $display("FAIL wrap_beat%0d data=%h last=%b want data=%h", i, up_q[i].data, up_q[i].last, mem[(i + 1) % 4]);
      end
    end
    r = '{id: 8'h06, addr: 12'h040, len: 8'd31, size: 3'd2, burst: 2'b00};
    start_read(r);
    wait_done(32, "fixed");
    checks++;
    if (mon_ar.size() != 1 || mon_ar[0] !== r || up_q.size() != 32 || up_q[31].last !== 1'b1 || up_q[30].last !== 1'b0) begin
      failures++;
      $display("FAIL fixed_long ars=%0d beats=%0d want one unchanged AR and 32 beats", mon_ar.size(), up_q.size());
    end
  endtask

  task automatic test_fifo_full();
    int nlast;
    r_stall = 1;
    start_read('{id: 8'h44, addr: 12'hF00, len: 8'd255, size: 3'd2, burst: 2'b01});
    for (int i = 0; i < 20; i++) step();
    checks++;
    if (mon_ar.size() != 2 || m_if.arvalid !== 1'b0) begin
      failures++;
      $display("FAIL fifo_full_hold ars=%0d arvalid=%b want 2/0", mon_ar.size(), m_if.arvalid);
    end
    r_stall = 0;
    wait_done(256, "fifo_full");
    checks++;
    if (mon_ar.size() != 16) begin
      failures++;
      $display("FAIL fifo_full_ar_count got=%0d want=16", mon_ar.size());
    end
    for (int k = 0; k < mon_ar.size(); k++) begin
      checks++;
      if (mon_ar[k].addr !== 12'(12'hF00 + k * 64) || mon_ar[k].len !== 8'd15) begin
        failures++;
        $display("FAIL fifo_full_ar%0d addr=%h len=%0d want addr=%h", k, mon_ar[k].addr, mon_ar[k].len, 12'(12'hF00 + k * 64));
      end
    end
    nlast = 0;
    for (int i = 0; i < up_q.size(); i++) if (up_q[i].last) nlast++;
    checks++;
    if (up_q.size() != 256 || nlast != 1 || up_q[255].last !== 1'b1) begin
      failures++;
      $display("FAIL fifo_full_beats got=%0d lasts=%0d want 256/1", up_q.size(), nlast);
    end
  endtask

  task automatic test_aclken();
    aclken = 1'b0;
    start_read('{id: 8'h55, addr: 12'h200, len: 8'd3, size: 3'd2, burst: 2'b01});
    for (int i = 0; i < 5; i++) step();
    checks++;
    if (mon_ar.size() != 0 || m_if.arvalid !== 1'b0 || s_if.arready !== 1'b1) begin
      failures++;
      $display("FAIL aclken_freeze ars=%0d arvalid=%b arready=%b want 0/0/1", mon_ar.size(), m_if.arvalid, s_if.arready);
    end
    aclken = 1'b1;
    wait_done(4, "aclken");
    checks++;
    if (mon_ar.size() != 1 || mon_ar[0].addr !== 12'h200 || mon_ar[0].len !== 8'd3 ||
        up_q.size() != 4 || up_q[3].last !== 1'b1) begin
      failures++;
      $display("FAIL aclken_resume ars=%0d beats=%0d", mon_ar.size(), up_q.size());
    end
  endtask

  task automatic test_reset_mid();
    int n;
    r_stall = 1;
    start_read('{id: 8'h66, addr: 12'h000, len: 8'd63, size: 3'd2, burst: 2'b01});
    n = 0;
    while (mon_ar.size() < 2 && n < 50) begin
      step();
      n++;
    end
    step();
    checks++;
    if (mon_ar.size() != 2 || m_if.arvalid !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_pre ars=%0d arvalid=%b want 2/0", mon_ar.size(), m_if.arvalid);
    end
    s_if.rready = 1'b0;
    m_if.rvalid = 1'b1;
    m_if.rlast  = 1'b1;
    #1;
    checks++;
    if (s_if.rlast !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_mask rlast=%b want=0", s_if.rlast);
    end
    aresetn = 1'b0;
    #1;
    checks++;
    if (s_if.arready !== 1'b0 || m_if.arvalid !== 1'b0 || s_if.rlast !== 1'b1) begin
      failures++;
      $display("FAIL rstmid_state arready=%b arvalid=%b rlast=%b want 0/0/1", s_if.arready, m_if.arvalid, s_if.rlast);
    end
    m_if.rvalid = 1'b0;
    m_if.rlast  = 1'b0;
    ds_q.delete();
    ds_beat = 0;
    r_stall = 0;
    for (int i = 0; i < 3; i++) step();
    aresetn = 1'b1;
    step();
    start_read('{id: 8'h77, addr: 12'h300, len: 8'd3, size: 3'd2, burst: 2'b01});
    wait_done(4, "rstmid");
    checks++;
    if (mon_ar.size() != 1 || mon_ar[0].addr !== 12'h300 || mon_ar[0].len !== 8'd3 ||
        up_q.size() != 4 || up_q[3].last !== 1'b1 || up_q[3].data !== mem_at(12'h30C)) begin
      failures++;
      $display("FAIL rstmid_after ars=%0d beats=%0d", mon_ar.size(), up_q.size());
    end
  endtask

  task automatic test_random();
    ar_t   r;
    beat_t e;
    int    sel;
    rand_ready = 1;
    for (int t = 0; t < 20; t++) begin
      sel = $urandom_range(0, 9);
      r.id   = 8'($urandom);
      r.size = 3'd2;
      r.addr = 12'($urandom) & 12'hFFC;
      if (sel < 7) begin
        r.burst = 2'b01;
        r.len   = (sel < 3) ? 8'($urandom_range(0, 40)) : 8'($urandom);
      end else if (sel < 9) begin
        r.burst = 2'b10;
        r.len   = 8'((2 << $urandom_range(0, 3)) - 1);
      end else begin
        r.burst = 2'b00;
        r.len   = 8'($urandom_range(0, 40));
      end
      model_split(r);
      start_read(r);
      wait_done(int'(r.len) + 1, "random");
      checks++;
      if (mon_ar.size() != exp_ar.size()) begin
        failures++;
        $display("FAIL random%0d_ar_count got=%0d want=%0d", t, mon_ar.size(), exp_ar.size());
      end
      for (int k = 0; k < mon_ar.size() && k < exp_ar.size(); k++) begin
        checks++;
        if (mon_ar[k] !== exp_ar[k]) begin
          failures++;
          $display("FAIL random%0d_ar%0d got=%h want=%h", t, k, mon_ar[k], exp_ar[k]);
        end
      end
      checks++;
      if (up_q.size() != int'(r.len) + 1) begin
        failures++;
        $display("FAIL random%0d_beat_count got=%0d want=%0d", t, up_q.size(), int'(r.len) + 1);
      end
      for (int i = 0; i < up_q.size(); i++) begin
        e = {mem_at(beat_addr(r, i)), (i == int'(r.len)), r.id, r.id[1:0]};
        checks++;
        if (up_q[i] !== e) begin
          failures++;
          $display("FAIL random%0d_beat%0d got=%h want=%h", t, i, up_q[i], e);
        end
      end
    end
    rand_ready = 0;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = $urandom;
    mem[8] = 32'h12345678;
    s_if.arid = '0;  s_if.araddr = '0; s_if.arlen = '0; s_if.arsize = '0; s_if.arburst = '0;
    s_if.arvalid = 1'b0;
    s_if.rready  = 1'b1;
    m_if.arready = 1'b1;
    m_if.rvalid  = 1'b0;
    m_if.rid = '0; m_if.rdata = '0; m_if.rresp = '0; m_if.rlast = 1'b0;
    test_reset();
    test_split_64();
    test_single();
    test_len20();
    test_wrap_fixed();
    test_fifo_full();
    test_aclken();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end
endmodule
